// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//
// Contents:
//   div_state_e        FSM state encoding (IDLE, RUN, DONE).
//   DIV_DEFAULT_WIDTH  default operand/result width.
//   div_cnt_w()        iteration counter width.
//
// The counter must hold the value WIDTH, not just WIDTH-1. It counts the
// WIDTH restoring steps and then the result write-back cycle.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_DEFAULT_WIDTH = 32;

    function automatic int div_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Operand/result bundle between the EX stage and the iterative divider.
//
// Signals:
//   start_i     request a divide
//   dividend_i  dividend (WIDTH)
//   divisor_i   divisor (WIDTH)
//   signed_i    two's complement operands (only with DIV_SIGNED_EN)
//   busy_o      divider not idle
//   done_o      one-cycle completion pulse
//   div0_o      last completed divide had a zero divisor
//   quotient_o  last quotient, held until the next completion
//   remainder_o last remainder, held until the next completion
//
// Handshake:
// - start_i together with its operands is accepted on a rising edge where
//   busy_o is low. busy_o is the only back-pressure, so the requester must
//   hold start_i until it sees busy_o rise.
// - start_i is ignored while busy_o is high.
// - done_o marks the first cycle in which the new results are valid.
//
// Modports: master = requester (EX stage), slave = divider.
interface iterative_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) ();

    logic             start_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
`ifdef DIV_SIGNED_EN
    logic             signed_i;
`endif
    logic             busy_o;
    logic             done_o;
    logic             div0_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;

    modport master (
        output start_i, dividend_i, divisor_i,
`ifdef DIV_SIGNED_EN
               signed_i,
`endif
        input  busy_o, done_o, div0_o, quotient_o, remainder_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
`ifdef DIV_SIGNED_EN
               signed_i,
`endif
        output busy_o, done_o, div0_o, quotient_o, remainder_o
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
//
// Ports:
//   i_rem  partial remainder (WIDTH+1)
//   i_quo  quotient shift register; it holds the remaining dividend bits in
//          its upper part (WIDTH)
//   i_div  divisor magnitude (WIDTH)
//   o_rem  next partial remainder (WIDTH+1)
//   o_quo  next quotient shift register (WIDTH)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_neg;

    always_comb begin
        // Shift {rem, quo} left by one. The trial difference gets one spare
        // bit above the remainder so that its MSB acts as the borrow.
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_trial = w_shift - {2'b00, i_div};
        w_neg   = w_trial[WIDTH+1];
        o_rem   = w_neg ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
        o_quo   = {i_quo[WIDTH-2:0], ~w_neg};
    end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring integer divider for the EX stage.
//
// Timing:
// - A non-zero-divisor request accepted at edge 0 runs WIDTH restoring steps
//   on edges 1..WIDTH.
// - The results are written and DONE is entered on edge WIDTH+1.
// - A zero divisor goes straight to DONE on edge 0.
//
// Optional feature: define DIV_SIGNED_EN to add signed_i.
// - Signed operands are converted to magnitudes on acceptance.
// - The result signs are corrected when the results are written back.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   bus          iterative_divider_if slave (operands, handshake, results)
//   dbg_state_o  current FSM state, for observation only
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    iterative_divider_if.slave   bus,
    output div_state_e           dbg_state_o
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_q_out;
    logic [WIDTH-1:0] r_r_out;
`ifdef DIV_SIGNED_EN
    logic             r_q_neg;
    logic             r_r_neg;
    logic             w_a_neg;
    logic             w_b_neg;
`endif

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;
    logic [WIDTH:0]   w_next_rem;
    logic [WIDTH-1:0] w_next_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_next_rem),
        .o_quo (w_next_quo)
    );

    always_comb begin
        w_a_mag = bus.dividend_i;
        w_b_mag = bus.divisor_i;
        w_q_fin = r_quo;
        w_r_fin = r_rem[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
        w_a_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
        w_b_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
        // The most-negative value maps onto itself. Read as an unsigned
        // magnitude it is still correct.
        if (w_a_neg) w_a_mag = -bus.dividend_i;
        if (w_b_neg) w_b_mag = -bus.divisor_i;
        if (r_q_neg) w_q_fin = -r_quo;
        if (r_r_neg) w_r_fin = -r_rem[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_q_out <= '0;
            r_r_out <= '0;
`ifdef DIV_SIGNED_EN
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_busy <= 1'b1;
                        if (bus.divisor_i == '0) begin
                            // A zero divisor needs no iterations. The raw
                            // dividend is reported as the remainder.
                            r_q_out <= '1;
                            r_r_out <= bus.dividend_i;
                            r_div0  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_div   <= w_b_mag;
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_cnt   <= '0;
`ifdef DIV_SIGNED_EN
                            r_q_neg <= w_a_neg ^ w_b_neg;
                            r_r_neg <= w_a_neg;
`endif
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        // All steps are done. This cycle writes back the
                        // sign-corrected results.
                        r_q_out <= w_q_fin;
                        r_r_out <= w_r_fin;
                        r_div0  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_rem <= w_next_rem;
                        r_quo <= w_next_quo;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.div0_o      = r_div0;
    assign bus.quotient_o  = r_q_out;
    assign bus.remainder_o = r_r_out;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider (default WIDTH = 32).
// Signed cases run only when DIV_SIGNED_EN is defined.
module tb_iterative_divider;
    import div_pkg::*;

    localparam int W     = 32;
    localparam int EXP_W = 2 * W + 1;

    logic       clk_i;
    logic       rst_i;
    div_state_e dbg_state;

    iterative_divider_if #(.WIDTH(W)) bus ();

    iterative_divider #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [W-1:0] m_q    = '0;
    logic [W-1:0] m_r    = '0;
    logic         m_div0 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // The reference model works from plain arithmetic on the operands.
    function automatic logic [EXP_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sgn);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            return {1'b0, qv[W-1:0], rv[W-1:0]};
        end
        return {1'b0, a / b, a % b};
    endfunction

    // Compare process: track the held results, then check them every cycle.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            if (bus.done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done_o=1 expected no completion");
                end else begin
                    logic [EXP_W-1:0] e;
                    e      = exp_q.pop_front();
                    m_div0 = e[2*W];
                    m_q    = e[2*W-1:W];
                    m_r    = e[W-1:0];
                end
            end
            chk("held_quotient", bus.quotient_o, m_q);
            chk("held_remainder", bus.remainder_o, m_r);
            chk("held_div0", bus.div0_o, m_div0);
        end
    end

    // ---------------- driver tasks ----------------
    // poke > 0: issue an extra start sampled at that edge of the run.
    // poke = -1: hold start high across the edge that leaves DONE.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           input int poke, input string tag);
        int edges;
        bit seen;
        @(negedge clk_i);
        chk({tag, "_idle_before"}, bus.busy_o, 0);
        bus.start_i    = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
`ifdef DIV_SIGNED_EN
        bus.signed_i   = sgn;
`endif
        exp_q.push_back(model(a, b, sgn));
        @(posedge clk_i);
        #1;
        bus.start_i    = 1'b0;
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
        chk({tag, "_busy_after_accept"}, bus.busy_o, 1);
        edges = 0;
        seen  = bus.done_o;
        while (!seen && edges < 200) begin
            @(posedge clk_i);
            #1;
            edges++;
            if (poke > 0 && edges == poke - 1) begin
                bus.start_i    = 1'b1;
                bus.dividend_i = 9;
                bus.divisor_i  = 3;
            end else begin
                bus.start_i = 1'b0;
            end
            seen = bus.done_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done_o within %0d edges expected done_o", tag, edges);
            exp_q.delete();
            return;
        end
        bus.start_i = 1'b0;
        chk({tag, "_latency"}, edges, (b == '0) ? 0 : W + 1);
        chk({tag, "_busy_in_done"}, bus.busy_o, 1);
        if (poke == -1) begin
            bus.start_i    = 1'b1;
            bus.dividend_i = 9;
            bus.divisor_i  = 3;
        end
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        chk({tag, "_busy_fall"}, bus.busy_o, 0);
        chk({tag, "_done_pulse"}, bus.done_o, 0);
        if (poke == -1) begin
            @(posedge clk_i);
            #1;
            chk({tag, "_start_in_done_ignored"}, bus.busy_o, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] a, b;
        logic sgn;
        int sel, poke;

        rst_i          = 1'b0;
        bus.start_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
`ifdef DIV_SIGNED_EN
        bus.signed_i   = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_div0", bus.div0_o, 0);
        chk("rst_quotient", bus.quotient_o, 0);
        chk("rst_remainder", bus.remainder_o, 0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Pin the model itself with hand-computed values.
        chk("model_100_7", model(100, 7, 0), {1'b0, 32'd14, 32'd2});
        chk("model_5_0", model(5, 0, 0), {1'b1, 32'hFFFF_FFFF, 32'd5});
        chk("model_s_m7_2", model(32'hFFFF_FFF9, 2, 1), {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        chk("model_s_min_m1", model(32'h8000_0000, 32'hFFFF_FFFF, 1), {1'b0, 32'h8000_0000, 32'd0});

        // Directed cases.
        run_div(100, 7, 0, 0, "d100_7");
        chk("q_100_7", bus.quotient_o, 14);
        chk("r_100_7", bus.remainder_o, 2);
        chk("z_100_7", bus.div0_o, 0);

        run_div(32'hFFFF_FFFF, 1, 0, 0, "dmax_1");
        chk("q_max_1", bus.quotient_o, 32'hFFFF_FFFF);
        chk("r_max_1", bus.remainder_o, 0);
        run_div(3, 32'hFFFF_FFFF, 0, 0, "d3_max");
        chk("q_3_max", bus.quotient_o, 0);
        chk("r_3_max", bus.remainder_o, 3);

        run_div(5, 0, 0, 0, "d5_0");
        chk("q_5_0", bus.quotient_o, 32'hFFFF_FFFF);
        chk("r_5_0", bus.remainder_o, 5);
        chk("z_5_0", bus.div0_o, 1);

        run_div(100, 7, 0, 10, "dignore");
        chk("q_ignore", bus.quotient_o, 14);
        chk("r_ignore", bus.remainder_o, 2);

        run_div(77, 5, 0, -1, "ddone_ign");

        // Reset in the middle of a run.
        @(negedge clk_i);
        bus.start_i    = 1'b1;
        bus.dividend_i = 100;
        bus.divisor_i  = 7;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        repeat (14) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_done", bus.done_o, 0);
        chk("midrst_div0", bus.div0_o, 0);
        chk("midrst_quotient", bus.quotient_o, 0);
        chk("midrst_remainder", bus.remainder_o, 0);
        exp_q.delete();
        m_q    = '0;
        m_r    = '0;
        m_div0 = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        run_div(20, 6, 0, 0, "d20_6");
        chk("q_20_6", bus.quotient_o, 3);
        chk("r_20_6", bus.remainder_o, 2);

`ifdef DIV_SIGNED_EN
        run_div(32'hFFFF_FFF9, 2, 1, 0, "s_m7_2");
        chk("q_s_m7_2", bus.quotient_o, 32'hFFFF_FFFD);
        chk("r_s_m7_2", bus.remainder_o, 32'hFFFF_FFFF);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "s_min_m1");
        chk("q_s_min_m1", bus.quotient_o, 32'h8000_0000);
        chk("r_s_min_m1", bus.remainder_o, 0);
        run_div(32'hFFFF_FFFB, 0, 1, 0, "s_m5_0");
        chk("q_s_m5_0", bus.quotient_o, 32'hFFFF_FFFF);
        chk("r_s_m5_0", bus.remainder_o, 32'hFFFF_FFFB);
`endif

        // Randomized, back-to-back requests.
        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 300);
            case (sel)
                0:       b = '0;
                1, 2, 3: b = $urandom_range(1, 15);
                4:       b = '1;
                default: b = $urandom;
            endcase
            sgn = 1'b0;
`ifdef DIV_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
`endif
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W)) : 0;
            run_div(a, b, sgn, poke, "rand");
        end

        repeat (2) @(posedge clk_i);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle restoring integer divider for the EX stage: the inverse companion of the single-cycle ALU's add/sub/or/and/multiply set. It computes quotient and remainder over WIDTH iteration cycles. It exposes a start/busy/done handshake so that hazard control can stall the pipeline while a divide is in flight. It sits beside the ALU and is fed the same two operand buses.

## Interface
- WIDTH, 32, operand and result width in bits; must be 2 or more.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous, active-low reset.
- start_i  input  1  request a divide; sampled only in IDLE.
- dividend_i  input  WIDTH  dividend; sampled on the accepting edge.
- divisor_i  input  WIDTH  divisor; sampled on the accepting edge.
- signed_i  input  1  treat operands as two's complement; present only with DIV_SIGNED_EN.
- busy_o  output  1  high whenever the state is not IDLE.
- done_o  output  1  one-cycle pulse; results valid from this cycle onward.
- div0_o  output  1  the last completed divide had divisor 0; held with the results.
- quotient_o  output  WIDTH  last quotient; held until the next completion.
- remainder_o  output  WIDTH  last remainder; held until the next completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start_i=1, divisor≠0: latch operands; clear the partial remainder; set the iteration counter to 0; go to RUN.
- IDLE, start_i=1, divisor=0: go directly to DONE.
  - quotient_o = all-ones, remainder_o = dividend, div0_o = 1.
- RUN, each edge: one restoring step.
  - Shift {rem, quo} left by 1. Subtract the divisor from the upper half.
  - If the result is non-negative, keep it and set the quotient LSB to 1. Otherwise restore and set the LSB to 0.
  - The counter increments. After step WIDTH−1, write the results to the outputs, set div0_o = 0, and go to DONE.
- DONE: done_o = 1 for exactly this cycle. Next edge goes unconditionally to IDLE.
- start_i in RUN or DONE is ignored. There is no queueing, and the operands are not re-sampled.
- Arithmetic: the unsigned partial remainder needs WIDTH+1 bits internally. Outputs are truncated to WIDTH bits.
- Reset, including mid-RUN: state = IDLE, counter = 0, busy_o = 0, done_o = 0, div0_o = 0, quotient_o = 0, remainder_o = 0. Any in-flight divide is discarded.

## Timing
- Call the edge that accepts start_i edge 0.
- Normal divide:
  - busy_o is high from after edge 0 through the DONE cycle.
  - done_o is high in the cycle after edge WIDTH+1, which is 33 edges for WIDTH=32.
  - busy_o falls after the following edge.
- Divide by zero: done_o is high in the cycle after edge 0, a latency of 1. busy_o is high only during that cycle.
- Results change only on the edge entering DONE. They are stable for any number of cycles afterwards.
- Back-to-back: the earliest next accepting edge is the edge that leaves DONE to IDLE, plus one.

## Configuration
- DIV_SIGNED_EN defined:
  - The signed_i port exists.
  - When signed_i=1, operands are converted to magnitudes on acceptance. The run is unsigned. Sign is corrected when writing the results.
  - Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend).
  - Most-negative ÷ −1 gives quotient 0x8000_0000 and remainder 0.
  - Divide by zero behaves as in the unsigned case: quotient all-ones (−1), remainder = dividend.
- DIV_SIGNED_EN undefined: no signed_i port. The divider is unsigned only, with no sign logic.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the DIV_DEFAULT_WIDTH constant;
  - a counter-width helper based on $clog2(WIDTH).
- Sub-module div_step is a purely combinational single restoring step.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder and next quotient.
  - The FSM and registers stay in iterative_divider.

## Test plan
- 100 ÷ 7 unsigned -> after 33 edges: done_o=1, quotient_o=14, remainder_o=2, div0_o=0; busy_o low one edge later.
- 0xFFFF_FFFF ÷ 1 -> quotient_o=0xFFFF_FFFF, remainder_o=0; then 3 ÷ 0xFFFF_FFFF -> quotient_o=0, remainder_o=3.
- 5 ÷ 0 -> done_o in the cycle after acceptance, div0_o=1, quotient_o=0xFFFF_FFFF, remainder_o=5.
- 100 ÷ 7 started, then at edge 10 start_i=1 with 9 ÷ 3 -> second request ignored; result is 14 r 2 at edge 33.
- rst_i=0 at edge 15 of a run -> next cycle busy_o=0, done_o=0, all outputs 0; a fresh 20 ÷ 6 then gives 3 r 2 at edge 33.
- DIV_SIGNED_EN, signed_i=1:
  - −7 ÷ 2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF.
  - 0x8000_0000 ÷ 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0.
